hazard_ctrl_param: RTL and testbench

//  Parametrised hazard/forwarding controller for the 4-stage pipeline (ID/EX/MEM/WB).

---
 rtl/hazard_ctrl_param.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl_param.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_param.sv
// Hazard/forwarding controller for the ID/EX/MEM/WB pipeline: operand forwarding selects,
// load-use and early-operand stalls, data-read tracking with timeout, and redirect flush.
module hazard_ctrl_param #(
    parameter int RA_W       = 4,
    parameter int LU_STALL   = 1,
    parameter int FLUSH_CYC  = 1,
    parameter int RD_TIMEOUT = 15,
    parameter int ZERO_REG   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            id_early,
    input  logic [RA_W-1:0] id_ra1,
    input  logic [RA_W-1:0] id_ra2,
    input  logic            ex_wen,
    input  logic            ex_load,
    input  logic [RA_W-1:0] ex_wa,
    input  logic            mem_wen,
    input  logic [RA_W-1:0] mem_wa,
    input  logic            wb_wen,
    input  logic [RA_W-1:0] wb_wa,
    input  logic            redirect,
    input  logic            inst_ready,
    input  logic            data_read,
    input  logic            data_ready,
    output logic [1:0]      fwd1,
    output logic [1:0]      fwd2,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_all,
    output logic            flush,
    output logic            rd_err
);

    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [1:0] LU_LOAD    = 2'(LU_STALL - 1);
    localparam logic [1:0] FL_LOAD    = 2'(FLUSH_CYC);
    localparam logic [1:0] FL_LOAD_M1 = 2'(FLUSH_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    function automatic logic match(input logic wen, input logic [RA_W-1:0] a,
                                   input logic [RA_W-1:0] wa);
        return wen && (a == wa) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    rd_state_e        state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rd_err_q, rd_err_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic [1:0]       fl_cnt_q, fl_cnt_d;

    logic       ex1, mem1, wb1, ex2, mem2, wb2;
    logic       hazard, flush_c, stall_id_c, stall_all_c;
    logic [1:0] fwd1_c, fwd2_c;

    assign ex1  = match(ex_wen,  id_ra1, ex_wa);
    assign mem1 = match(mem_wen, id_ra1, mem_wa);
    assign wb1  = match(wb_wen,  id_ra1, wb_wa);
    assign ex2  = match(ex_wen,  id_ra2, ex_wa);
    assign mem2 = match(mem_wen, id_ra2, mem_wa);
    assign wb2  = match(wb_wen,  id_ra2, wb_wa);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fwd1_c = 2'd0;
        fwd2_c = 2'd0;
        if (id_use1) begin
            if (ex1 && !ex_load) fwd1_c = 2'd1;
            else if (mem1)       fwd1_c = 2'd2;
            else if (wb1)        fwd1_c = 2'd3;
        end
        if (id_use2) begin
            if (ex2 && !ex_load) fwd2_c = 2'd1;
            else if (mem2)       fwd2_c = 2'd2;
            else if (wb2)        fwd2_c = 2'd3;
        end
    end

    assign hazard = (ex_load && ((id_use1 && ex1) || (id_use2 && ex2)))
                 || (id_early && id_use2 && ex2);

    assign stall_all_c = !data_ready
                      && ((state_q == RD_WAIT) || ((state_q == RD_IDLE) && data_read));
    assign flush_c     = redirect || (fl_cnt_q != 2'd0);
    assign stall_id_c  = !flush_c && ((lu_cnt_q != 2'd0) || hazard);

    // The load cycle itself counts as the first stall/flush cycle, hence the -1 loads.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (flush_c)                 lu_cnt_d = 2'd0;
        else if (stall_all_c)        lu_cnt_d = lu_cnt_q;
        else if (lu_cnt_q != 2'd0)   lu_cnt_d = lu_cnt_q - 2'd1;
        else if (hazard)             lu_cnt_d = (id_early && ex_load) ? 2'd1 : LU_LOAD;

        fl_cnt_d = fl_cnt_q;
        if (redirect)                               fl_cnt_d = stall_all_c ? FL_LOAD : FL_LOAD_M1;
        else if (!stall_all_c && fl_cnt_q != 2'd0)  fl_cnt_d = fl_cnt_q - 2'd1;
    end

    // tmo_q counts stall cycles already spent on the outstanding read, the issue cycle included.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        rd_err_d = rd_err_q;
        case (state_q)
            RD_IDLE: begin
                if (data_read && !data_ready) begin
                    if (RD_TIMEOUT == 1) begin
                        rd_err_d = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        tmo_d   = TMO_W'(1);
                    end
                end
            end
            RD_WAIT: begin
                if (data_ready) begin
                    state_d = RD_IDLE;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = RD_IDLE;
                    tmo_d    = '0;
                    rd_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RD_IDLE;
            tmo_q    <= '0;
            rd_err_q <= 1'b0;
            lu_cnt_q <= 2'd0;
            fl_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            rd_err_q <= rd_err_d;
            lu_cnt_q <= lu_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    // Outputs are forced low combinationally while reset is held, even with live inputs.
    assign fwd1      = rst ? fwd1_c : 2'd0;
    assign fwd2      = rst ? fwd2_c : 2'd0;
    assign stall_id  = rst && stall_id_c;
    assign stall_if  = rst && (stall_id_c || !inst_ready);
    assign stall_all = rst && stall_all_c;
    assign flush     = rst && flush_c;
    assign rd_err    = rst && rd_err_q;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: forwarding vector table, directed multi-cycle sequences,
// and randomized traffic checked each cycle against a cycle-count reference model.
module tb_hazard_ctrl_param;

    localparam int RA_W       = 4;
    localparam int LU_STALL   = 2;
    localparam int FLUSH_CYC  = 2;
    localparam int RD_TIMEOUT = 6;
    localparam int ZERO_REG   = 1;

    logic            clk, rst;
    logic            id_use1, id_use2, id_early;
    logic [RA_W-1:0] id_ra1, id_ra2, ex_wa, mem_wa, wb_wa;
    logic            ex_wen, ex_load, mem_wen, wb_wen;
    logic            redirect, inst_ready, data_read, data_ready;
    logic [1:0]      fwd1, fwd2;
    logic            stall_if, stall_id, stall_all, flush, rd_err;

    hazard_ctrl_param #(
        .RA_W(RA_W), .LU_STALL(LU_STALL), .FLUSH_CYC(FLUSH_CYC),
        .RD_TIMEOUT(RD_TIMEOUT), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .rst(rst),
        .id_use1(id_use1), .id_use2(id_use2), .id_early(id_early),
        .id_ra1(id_ra1), .id_ra2(id_ra2),
        .ex_wen(ex_wen), .ex_load(ex_load), .ex_wa(ex_wa),
        .mem_wen(mem_wen), .mem_wa(mem_wa),
        .wb_wen(wb_wen), .wb_wa(wb_wa),
        .redirect(redirect), .inst_ready(inst_ready),
        .data_read(data_read), .data_ready(data_ready),
        .fwd1(fwd1), .fwd2(fwd2),
        .stall_if(stall_if), .stall_id(stall_id), .stall_all(stall_all),
        .flush(flush), .rd_err(rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: remaining bubbles/flush cycles and elapsed read stall cycles.
    int m_bubbles, m_flush_left, m_rd_cycles;
    bit m_rd_wait, m_rd_err;

    task automatic model_reset();
        m_bubbles = 0; m_flush_left = 0; m_rd_cycles = 0; m_rd_wait = 0; m_rd_err = 0;
    endtask

    function automatic int model_fwd(input bit use_op, input int ra);
        int wa[3];
        bit ok[3];
        wa = '{int'(ex_wa), int'(mem_wa), int'(wb_wa)};
        ok = '{ex_wen && !ex_load, mem_wen, wb_wen};
        if (!use_op || (ZERO_REG != 0 && ra == 0)) return 0;
        for (int s = 0; s < 3; s++)
            if (ok[s] && wa[s] == ra) return s + 1;
        return 0;
    endfunction

    function automatic bit model_hazard();
        bit ex_target = ex_wen && !(ZERO_REG != 0 && ex_wa == 0);
        bit needs1 = id_use1 && id_ra1 == ex_wa;
        bit needs2 = id_use2 && id_ra2 == ex_wa;
        return ex_target && ((ex_load && (needs1 || needs2)) || (id_early && needs2));
    endfunction

    function automatic bit exp_flush();
        return redirect || m_flush_left > 0;
    endfunction
    function automatic bit exp_stall_all();
        return !data_ready && (m_rd_wait || data_read);
    endfunction
    function automatic bit exp_stall_id();
        return !exp_flush() && (m_bubbles > 0 || model_hazard());
    endfunction

    task automatic model_check(input string p);
        check({p, "_fwd1"},      fwd1,      model_fwd(id_use1, id_ra1));
        check({p, "_fwd2"},      fwd2,      model_fwd(id_use2, id_ra2));
        check({p, "_stall_id"},  stall_id,  exp_stall_id());
        check({p, "_stall_if"},  stall_if,  exp_stall_id() || !inst_ready);
        check({p, "_stall_all"}, stall_all, exp_stall_all());
        check({p, "_flush"},     flush,     exp_flush());
        check({p, "_rd_err"},    rd_err,    m_rd_err);
    endtask

    task automatic model_step();
        bit sa  = exp_stall_all();
        bit fl  = exp_flush();
        bit haz = model_hazard();
        if (redirect) m_flush_left = sa ? FLUSH_CYC : FLUSH_CYC - 1;
        else if (!sa && m_flush_left > 0) m_flush_left--;
        if (fl) m_bubbles = 0;
        else if (!sa) begin
            if (m_bubbles > 0) m_bubbles--;
            else if (haz) m_bubbles = (id_early && ex_load) ? 1 : LU_STALL - 1;
        end
        if (m_rd_wait) begin
            if (data_ready) m_rd_wait = 0;
            else begin
                m_rd_cycles++;
                if (m_rd_cycles >= RD_TIMEOUT) begin m_rd_wait = 0; m_rd_err = 1; end
            end
        end else if (data_read && !data_ready) begin
            m_rd_cycles = 1;
            if (RD_TIMEOUT <= 1) m_rd_err = 1; else m_rd_wait = 1;
        end
    endtask

    // Inputs are driven at posedge+1; settle moves to posedge+4 for sampling.
    task automatic settle();
        #3;
    endtask
    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_use1 = 0; id_use2 = 0; id_early = 0; id_ra1 = '0; id_ra2 = '0;
        ex_wen = 0; ex_load = 0; ex_wa = '0; mem_wen = 0; mem_wa = '0; wb_wen = 0; wb_wa = '0;
        redirect = 0; inst_ready = 1; data_read = 0; data_ready = 0;
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            settle(); model_check("idle"); advance();
        end
    endtask

    task automatic load_use_inputs();
        id_use1 = 1; id_ra1 = 4'd3; ex_wen = 1; ex_load = 1; ex_wa = 4'd3;
    endtask

    typedef struct {
        string name;
        bit u1, u2, early;
        int ra1, ra2;
        bit exw, exl; int exa;
        bit mw; int ma;
        bit ww; int wa;
        int f1, f2;
        bit sid;
    } vec_t;

    vec_t vecs[10];
    bit   prev_read;

    initial begin
        vecs[0] = '{"ex_all5",     0,1,0, 0,5, 1,0,5, 1,5, 1,5, 0,1, 0};
        vecs[1] = '{"zero_reg",    0,1,0, 0,0, 1,1,0, 1,0, 1,0, 0,0, 0};
        vecs[2] = '{"mem_over_wb", 1,0,0, 7,0, 1,0,2, 1,7, 1,7, 2,0, 0};
        vecs[3] = '{"wb_only",     1,1,0, 9,9, 0,0,0, 0,0, 1,9, 3,3, 0};
        vecs[4] = '{"load_mem",    1,0,0, 4,0, 1,1,4, 1,4, 0,0, 2,0, 1};
        vecs[5] = '{"unused_op",   0,0,0, 4,0, 1,1,4, 0,0, 0,0, 0,0, 0};
        vecs[6] = '{"early_ex",    0,1,1, 0,6, 1,0,6, 0,0, 0,0, 0,1, 1};
        vecs[7] = '{"early_nouse", 0,0,1, 0,6, 1,0,6, 0,0, 0,0, 0,0, 0};
        vecs[8] = '{"ex_nowen",    1,0,0, 8,0, 0,0,8, 0,0, 1,8, 3,0, 0};
        vecs[9] = '{"both_ops",    1,1,0, 1,2, 1,0,1, 1,2, 0,0, 1,2, 0};

        // Reset state: outputs low even with inst_ready low.
        idle_inputs();
        inst_ready = 0;
        rst = 0;
        model_reset();
        #2;
        check("reset_stall_if", stall_if, 0);
        check("reset_outputs", {fwd1, fwd2, stall_id, stall_all, flush, rd_err}, 0);
        @(posedge clk); @(posedge clk);
        #3 rst = 1;
        @(posedge clk); #1;
        idle_cycles(2);

        foreach (vecs[i]) begin
            idle_inputs();
            id_use1 = vecs[i].u1; id_use2 = vecs[i].u2; id_early = vecs[i].early;
            id_ra1 = RA_W'(vecs[i].ra1); id_ra2 = RA_W'(vecs[i].ra2);
            ex_wen = vecs[i].exw; ex_load = vecs[i].exl; ex_wa = RA_W'(vecs[i].exa);
            mem_wen = vecs[i].mw; mem_wa = RA_W'(vecs[i].ma);
            wb_wen = vecs[i].ww; wb_wa = RA_W'(vecs[i].wa);
            settle();
            check({vecs[i].name, "_fwd1"}, fwd1, vecs[i].f1);
            check({vecs[i].name, "_fwd2"}, fwd2, vecs[i].f2);
            check({vecs[i].name, "_stall_id"}, stall_id, vecs[i].sid);
            model_check(vecs[i].name);
            advance();
            idle_cycles(3);
        end

        idle_inputs();
        inst_ready = 0;
        settle();
        check("icache_stall_if", stall_if, 1);
        check("icache_stall_id", stall_id, 0);
        advance();
        idle_cycles(1);

        // Load-use: two bubbles, then the load result comes from MEM.
        load_use_inputs();
        settle();
        check("lu_c0_stall_id", stall_id, 1);
        advance();
        ex_wen = 0; ex_load = 0; mem_wen = 1; mem_wa = 4'd3;
        settle();
        check("lu_c1_stall_id", stall_id, 1);
        check("lu_c1_fwd1", fwd1, 2);
        advance();
        settle();
        check("lu_c2_stall_id", stall_id, 0);
        check("lu_c2_fwd1", fwd1, 2);
        model_check("lu_c2");
        advance();
        idle_cycles(2);

        // Read stalled 4 cycles while a load-use bubble is pending: bubble count frozen.
        load_use_inputs();
        settle(); model_check("rd4_c0"); advance();
        idle_inputs();
        data_read = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("rd4_stall_all", stall_all, 1);
            check("rd4_stall_id_frozen", stall_id, 1);
            model_check("rd4");
            advance();
            data_read = 0;
        end
        data_ready = 1;
        settle();
        check("rd4_done_stall_all", stall_all, 0);
        check("rd4_done_stall_id", stall_id, 1);
        check("rd4_rd_err", rd_err, 0);
        advance();
        data_ready = 0;
        settle();
        check("rd4_after_stall_id", stall_id, 0);
        advance();
        idle_cycles(1);

        // Redirect during a load-use stall.
        load_use_inputs();
        settle(); check("fl_c0_stall_id", stall_id, 1); advance();
        redirect = 1;
        settle();
        check("fl_c1_flush", flush, 1);
        check("fl_c1_stall_id", stall_id, 0);
        advance();
        idle_inputs();
        settle();
        check("fl_c2_flush", flush, 1);
        check("fl_c2_stall_id", stall_id, 0);
        advance();
        settle();
        check("fl_c3_flush", flush, 0);
        model_check("fl_c3");
        advance();
        idle_cycles(1);

        // Read timeout: RD_TIMEOUT stall cycles, then sticky rd_err.
        data_read = 1;
        for (int k = 0; k < RD_TIMEOUT; k++) begin
            settle();
            check("tmo_stall_all", stall_all, 1);
            check("tmo_rd_err_low", rd_err, 0);
            advance();
            data_read = 0;
        end
        for (int k = 0; k < 3; k++) begin
            data_ready = k[0];
            settle();
            check("tmo_after_stall_all", stall_all, 0);
            check("tmo_rd_err_sticky", rd_err, 1);
            model_check("tmo");
            advance();
        end
        idle_cycles(1);

        // Reset mid-WAIT with a bubble pending.
        load_use_inputs();
        settle(); model_check("rst_c0"); advance();
        idle_inputs();
        data_read = 1;
        settle(); check("rst_c1_stall_all", stall_all, 1); advance();
        data_read = 0;
        settle();
        check("rst_c2_wait_stall_id", stall_id, 1);
        rst = 0;
        redirect = 1; inst_ready = 0; id_use1 = 1; id_ra1 = 4'd3; mem_wen = 1; mem_wa = 4'd3;
        #1;
        check("rst_async_outputs",
              {fwd1, fwd2, stall_if, stall_id, stall_all, flush, rd_err}, 0);
        model_reset();
        @(posedge clk); #1;
        idle_inputs();
        #2 rst = 1;
        #1;
        check("rst_release_stall", {stall_id, stall_all, flush, rd_err}, 0);
        model_check("rst_rel0");
        advance();
        settle();
        check("rst_release_next", {stall_id, stall_all, flush}, 0);
        model_check("rst_rel1");
        advance();

        // Randomized traffic against the reference model.
        prev_read = 0;
        for (int c = 0; c < 1500; c++) begin
            id_use1   = 1'($urandom_range(0, 1));
            id_use2   = 1'($urandom_range(0, 1));
            id_early  = ($urandom_range(0, 3) == 0);
            id_ra1    = RA_W'($urandom_range(0, 3));
            id_ra2    = RA_W'($urandom_range(0, 3));
            ex_wen    = ($urandom_range(0, 3) != 0);
            ex_load   = ($urandom_range(0, 3) == 0);
            ex_wa     = RA_W'($urandom_range(0, 3));
            mem_wen   = 1'($urandom_range(0, 1));
            mem_wa    = RA_W'($urandom_range(0, 3));
            wb_wen    = 1'($urandom_range(0, 1));
            wb_wa     = RA_W'($urandom_range(0, 3));
            redirect  = ($urandom_range(0, 7) == 0);
            inst_ready = ($urandom_range(0, 7) != 0);
            data_read = !prev_read && !m_rd_wait && ($urandom_range(0, 9) == 0);
            data_ready = ($urandom_range(0, 3) == 0);
            prev_read = data_read;
            settle();
            model_check("rand");
            advance();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
